// File: rtl/seven_segment_multi_display_if.sv
// Load/value/mode bundle and display outputs between result logic and the
// seven-segment driver.
interface seven_segment_multi_display_if #(
  parameter int N_DIGITS   = 6,
  parameter int DATA_WIDTH = 20
);
  logic                    load;
  logic [DATA_WIDTH-1:0]   value;
  logic                    hex_mode;
  logic                    blank_lz;
  logic [N_DIGITS-1:0]     dp_mask;
  logic                    blink_en;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [8*N_DIGITS-1:0]   seg;

  modport master (
    output load, value, hex_mode, blank_lz, dp_mask, blink_en,
    input  busy, done, overflow, seg
  );

  modport slave (
    input  load, value, hex_mode, blank_lz, dp_mask, blink_en,
    output busy, done, overflow, seg
  );
endinterface

// File: rtl/seven_segment_multi_display.sv
// Multi-digit common-anode 7-segment driver: sequential double-dabble BCD or hex
// nibbles, leading-zero blanking, per-digit DP, overflow dashes, whole-display blink.
module seven_segment_multi_display #(
  parameter int N_DIGITS   = 6,
  parameter int DATA_WIDTH = 20,
  parameter int BLINK_DIV  = 25000000
) (
  input logic                         clk,
  input logic                         reset,
  seven_segment_multi_display_if.slave bus
);

  localparam int BW = 4 * N_DIGITS;
  localparam int SW = 8 * N_DIGITS;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int KW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  function automatic logic [63:0] pow10(int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(N_DIGITS);

  function automatic logic [6:0] seg7(logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  hex_q, hex_d, blz_q, blz_d, ovf_q, ovf_d, done_q, done_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [SW-1:0]         disp_q, disp_d, seg_q, seg_d;
  logic [KW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;

  logic [BW-1:0] hexv, adj, nibs;
  logic [SW-1:0] render;

  // Hex digits past the input width read as zero; input bits past the display are dropped.
  if (DATA_WIDTH >= BW) begin : g_hex_trunc
    assign hexv = shreg_q[BW-1:0];
  end else begin : g_hex_pad
    assign hexv = {{(BW-DATA_WIDTH){1'b0}}, shreg_q};
  end

  assign nibs = hex_q ? hexv : bcd_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    logic       seen;
    logic [6:0] g;
    render = '1;
    seen   = 1'b0;
    g      = 7'h7F;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (nibs[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
      if (ovf_q)                 g = 7'b1111110;
      else if (blz_q && !seen)   g = 7'b1111111;
      else                       g = seg7(nibs[4*i +: 4]);
      render[8*i +: 8] = {g, ~dp_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    blz_d   = blz_q;
    ovf_d   = ovf_q;
    dp_d    = dp_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.value;
          bcd_d   = '0;
          hex_d   = bus.hex_mode;
          blz_d   = bus.blank_lz;
          dp_d    = bus.dp_mask;
          ovf_d   = !bus.hex_mode && (64'(bus.value) >= LIMIT);
          cnt_d   = bus.hex_mode ? CW'(1) : CW'(DATA_WIDTH);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (!hex_q) begin
            bcd_d   = (adj << 1) | {{(BW-1){1'b0}}, shreg_q[DATA_WIDTH-1]};
            shreg_d = shreg_q << 1;
          end
        end else begin
          disp_d  = render;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink phase runs continuously so enabling blink never restarts the cadence.
  always_comb begin
    bcnt_d  = bcnt_q + KW'(1);
    phase_d = phase_q;
    if (bcnt_q == KW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = !phase_q;
    end
    seg_d = (bus.blink_en && !phase_d) ? '1 : disp_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      bcd_q   <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dp_q    <= '0;
      disp_q  <= '1;
      seg_q   <= '1;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      blz_q   <= blz_d;
      ovf_q   <= ovf_d;
      dp_q    <= dp_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.busy     = (state_q == CONVERT);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_seven_segment_multi_display.sv
// Scoreboard bench: loads push the model's expected display into a queue;
// a monitor pops and compares on every done pulse.
module tb_seven_segment_multi_display;
  localparam int N  = 6;
  localparam int DW = 20;
  localparam int BD = 4;
  localparam logic [8*N-1:0] ONES = '1;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    logic [8*N-1:0] seg;
    logic           ovf;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_segment_multi_display_if #(.N_DIGITS(N), .DATA_WIDTH(DW)) bus ();

  seven_segment_multi_display #(.N_DIGITS(N), .DATA_WIDTH(DW), .BLINK_DIV(BD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal digits by division, hex digits by shifting; blanking from the highest nonzero digit.
  function automatic exp_t model(int unsigned v, bit hex, bit blz, logic [N-1:0] dp);
    exp_t        e;
    int unsigned d [N];
    int unsigned p;
    int          msd;
    logic [6:0]  g;
    p   = 1;
    msd = 0;
    for (int i = 0; i < N; i++) begin
      d[i] = hex ? ((v >> (4 * i)) & 32'hF) : ((v / p) % 10);
      p    = p * 10;
      if (d[i] != 0) msd = i;
    end
    e.ovf = !hex && (v >= p);
    for (int i = 0; i < N; i++) begin
      if (e.ovf)                g = 7'b1111110;
      else if (blz && i > msd)  g = 7'b1111111;
      else                      g = GLYPH[d[i]];
      e.seg[8*i +: 8] = {g, ~dp[i]};
    end
    e.due = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int unsigned v, bit hex, bit blz, logic [N-1:0] dp);
    exp_t e;
    int   n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    if (bus.busy) check("busy_timeout", 64'(bus.busy), 64'd0);
    bus.load     = 1'b1;
    bus.value    = DW'(v);
    bus.hex_mode = hex;
    bus.blank_lz = blz;
    bus.dp_mask  = dp;
    tick();
    bus.load = 1'b0;
    e     = model(v, hex, blz, dp);
    e.due = cyc + (hex ? 2 : DW + 1);
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("seg", 64'(bus.seg), 64'(e.seg));
        check("overflow", 64'(bus.overflow), 64'(e.ovf));
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t           ce;
    logic [8*N-1:0] cont;
    bit             s [24];
    int             run, trans, bad, nd;
    bit             first;

    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.dp_mask  = '0;
    bus.blink_en = 1'b0;
    repeat (3) tick();
    check("reset_seg", 64'(bus.seg), 64'(ONES));
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_overflow", 64'(bus.overflow), 64'd0);
    reset = 1'b0;
    tick();

    do_load(123456, 0, 0, '0);
    check("busy_after_load", 64'(bus.busy), 64'd1);
    wait_idle();
    do_load(42, 0, 1, 6'b000010);
    wait_idle();
    do_load(20'hABCDE, 1, 0, '0);
    wait_idle();
    do_load(1000000, 0, 0, '0);
    wait_idle();
    do_load(0, 0, 1, 6'b000001);
    do_load(999999, 0, 1, '1);
    do_load(20'h00F00, 1, 1, 6'b101010);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      int unsigned v;
      v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 999) : $urandom_range(0, (1 << DW) - 1);
      do_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
    end
    wait_idle();

    // A load during conversion must be dropped.
    do_load(777, 0, 0, '0);
    repeat (3) tick();
    check("busy_mid_conversion", 64'(bus.busy), 64'd1);
    bus.load  = 1'b1;
    bus.value = DW'(999);
    tick();
    bus.load = 1'b0;
    wait_idle();

    do_load(31415, 0, 1, '0);
    repeat (5) tick();
    reset = 1'b1;
    sb.delete();
    #2;
    check("midreset_seg", 64'(bus.seg), 64'(ONES));
    check("midreset_busy", 64'(bus.busy), 64'd0);
    tick();
    reset = 1'b0;
    nd = 0;
    repeat (30) begin
      tick();
      if (bus.done) nd++;
    end
    check("no_done_after_reset", 64'(nd), 64'd0);
    check("seg_after_reset", 64'(bus.seg), 64'(ONES));
    check("busy_after_reset", 64'(bus.busy), 64'd0);

    do_load(123456, 0, 0, 6'b100001);
    wait_idle();
    ce   = model(123456, 0, 0, 6'b100001);
    cont = ce.seg;
    bus.blink_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      s[i] = (bus.seg == ONES);
      if (bus.seg != ONES && bus.seg != cont) bad++;
    end
    check("blink_levels", 64'(bad), 64'd0);
    run   = 1;
    trans = 0;
    first = 1'b1;
    for (int i = 1; i < 24; i++) begin
      if (s[i] == s[i-1]) begin
        run++;
      end else begin
        trans++;
        if (!first) check("blink_half_period", 64'(run), 64'(BD));
        first = 1'b0;
        run   = 1;
      end
    end
    check("blink_toggles", 64'(trans >= 4), 64'd1);
    bus.blink_en = 1'b0;
    tick();
    check("blink_off_restores", 64'(bus.seg), 64'(cont));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
